// File: rtl/voice_mixer_seq.sv
`default_nettype none
// ============================================================================
// Module   : voice_mixer_seq
// Purpose  : Voice slot sequencer plus per-voice panned stereo mixer. Drives
//            the stage counter / voice index for the synth pipeline, captures
//            one sample per slot, pans it, accumulates a frame and emits one
//            saturated stereo sample with a valid strobe per frame.
// Revision : 1.0 - initial release
// ============================================================================
module voice_mixer_seq #(
  parameter int NUM_VOICES   = 256,
  parameter int VOICE_IDX_W  = 8,
  parameter int STAGE_CYCLES = 3,
  parameter int SAMPLE_W     = 16,
  parameter int OUT_W        = 24,
  localparam int ACC_W       = SAMPLE_W + VOICE_IDX_W + 1,
  localparam int STATE_W     = (STAGE_CYCLES > 2) ? $clog2(STAGE_CYCLES) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_SPI_flag_pan,
  input  logic [VOICE_IDX_W-1:0]     i_SPI_voice_index,
  input  logic [7:0]                 i_SPI_pan,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic [VOICE_IDX_W-1:0]     i_sample_voice_index,
  output logic [STATE_W-1:0]         o_pipeline_state,
  output logic [VOICE_IDX_W-1:0]     o_voice_index,
  output logic signed [OUT_W-1:0]    o_sample_l,
  output logic signed [OUT_W-1:0]    o_sample_r,
  output logic                       o_sample_valid,
  output logic                       o_clip
);

  localparam logic [STATE_W-1:0]     LAST_STATE = STATE_W'(STAGE_CYCLES - 1);
  localparam logic [VOICE_IDX_W-1:0] LAST_VOICE = VOICE_IDX_W'(NUM_VOICES - 1);
  // Sample (SAMPLE_W) times a 10-bit non-negative signed gain.
  localparam int PROD_W = SAMPLE_W + 10;

  logic [7:0]                 pan_tbl [NUM_VOICES];
  logic [7:0]                 cap_pan;
  logic                       c_valid;
  logic signed [SAMPLE_W-1:0] c_sample;
  logic [VOICE_IDX_W-1:0]     c_idx;
  logic [8:0]                 c_gain_l;
  logic [7:0]                 c_gain_r;
  logic signed [PROD_W-1:0]   prod_l, prod_r, shr_l, shr_r;
  logic                       m_valid;
  logic [VOICE_IDX_W-1:0]     m_idx;
  logic signed [ACC_W-1:0]    m_l, m_r;
  logic signed [ACC_W-1:0]    acc_l, acc_r, sum_l, sum_r;
  logic signed [OUT_W-1:0]    sat_l, sat_r;
  logic                       ovf_l, ovf_r;

  // Stage counter and voice index issued to the pipeline head
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_pipeline_state <= '0;
      o_voice_index    <= '0;
    end else begin
      if (o_pipeline_state == LAST_STATE) o_pipeline_state <= '0;
      else                                o_pipeline_state <= o_pipeline_state + 1'b1;
      if (o_pipeline_state == '0) begin
        if (o_voice_index == LAST_VOICE) o_voice_index <= '0;
        else                             o_voice_index <= o_voice_index + 1'b1;
      end
    end
  end

  // Pan table; out-of-range write addresses match no entry and are dropped
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) pan_tbl[i] <= 8'd128;
    end else if (i_SPI_flag_pan) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (i_SPI_voice_index == VOICE_IDX_W'(i)) pan_tbl[i] <= i_SPI_pan;
    end
  end

  // Pan lookup for the incoming sample; out-of-range voices mix at centre pan
  always_comb begin
    cap_pan = 8'd128;
    for (int i = 0; i < NUM_VOICES; i++)
      if (i_sample_voice_index == VOICE_IDX_W'(i)) cap_pan = pan_tbl[i];
  end

  // Capture stage: sample, voice and gains latched on the last slot cycle.
  // The table read sees the pre-write value if a write lands on this edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      c_valid  <= 1'b0;
      c_sample <= '0;
      c_idx    <= '0;
      c_gain_l <= '0;
      c_gain_r <= '0;
    end else begin
      c_valid <= (o_pipeline_state == LAST_STATE);
      if (o_pipeline_state == LAST_STATE) begin
        c_sample <= i_sample;
        c_idx    <= i_sample_voice_index;
        c_gain_l <= 9'd256 - {1'b0, cap_pan};
        c_gain_r <= cap_pan;
      end
    end
  end

  assign prod_l = PROD_W'(c_sample) * PROD_W'($signed({1'b0, c_gain_l}));
  assign prod_r = PROD_W'(c_sample) * PROD_W'($signed({2'b00, c_gain_r}));
  assign shr_l  = prod_l >>> 8;
  assign shr_r  = prod_r >>> 8;

  // Multiply stage: panned products, sign-extended to accumulator width
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      m_valid <= 1'b0;
      m_idx   <= '0;
      m_l     <= '0;
      m_r     <= '0;
    end else begin
      m_valid <= c_valid;
      m_idx   <= c_idx;
      m_l     <= ACC_W'(shr_l);
      m_r     <= ACC_W'(shr_r);
    end
  end

  assign sum_l = acc_l + m_l;
  assign sum_r = acc_r + m_r;

  // Saturate by checking that all bits above the output sign bit agree
  generate
    if (OUT_W < ACC_W) begin : g_sat
      assign ovf_l = !((&sum_l[ACC_W-1:OUT_W-1]) || !(|sum_l[ACC_W-1:OUT_W-1]));
      assign ovf_r = !((&sum_r[ACC_W-1:OUT_W-1]) || !(|sum_r[ACC_W-1:OUT_W-1]));
      assign sat_l = ovf_l ? (sum_l[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                             : {1'b0, {(OUT_W-1){1'b1}}})
                           : sum_l[OUT_W-1:0];
      assign sat_r = ovf_r ? (sum_r[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                             : {1'b0, {(OUT_W-1){1'b1}}})
                           : sum_r[OUT_W-1:0];
    end else begin : g_nosat
      assign ovf_l = 1'b0;
      assign ovf_r = 1'b0;
      assign sat_l = OUT_W'(sum_l);
      assign sat_r = OUT_W'(sum_r);
    end
  endgenerate

  // Accumulate stage: last voice of the frame closes it and emits the output
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc_l          <= '0;
      acc_r          <= '0;
      o_sample_l     <= '0;
      o_sample_r     <= '0;
      o_sample_valid <= 1'b0;
      o_clip         <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      o_clip         <= 1'b0;
      if (m_valid) begin
        if (m_idx == LAST_VOICE) begin
          o_sample_l     <= sat_l;
          o_sample_r     <= sat_r;
          acc_l          <= '0;
          acc_r          <= '0;
          o_sample_valid <= 1'b1;
          o_clip         <= ovf_l | ovf_r;
        end else begin
          acc_l <= sum_l;
          acc_r <= sum_r;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_mixer_seq
// Purpose  : Directed self-checking bench for voice_mixer_seq (4 voices,
//            3 cycles per slot, 16-bit output). The upstream pipeline is
//            modelled as delivering the sample of the voice one slot behind
//            the head, so each frame after reset holds voices 0..3 in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_mixer_seq;
  localparam int NV = 4;
  localparam int IW = 8;
  localparam int SC = 3;
  localparam int SW = 16;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 spi_flag;
  logic [IW-1:0]        spi_idx;
  logic [7:0]           spi_pan;
  logic signed [SW-1:0] sample;
  logic [IW-1:0]        sample_idx;
  logic [1:0]           pstate;
  logic [IW-1:0]        vidx;
  logic signed [OW-1:0] out_l, out_r;
  logic                 valid, clip;
  logic signed [SW-1:0] samples [NV];
  logic [IW-1:0]        up_idx;
  int checks = 0;
  int errors = 0;

  voice_mixer_seq #(.NUM_VOICES(NV), .VOICE_IDX_W(IW), .STAGE_CYCLES(SC),
                    .SAMPLE_W(SW), .OUT_W(OW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_SPI_flag_pan(spi_flag),
    .i_SPI_voice_index(spi_idx), .i_SPI_pan(spi_pan), .i_sample(sample),
    .i_sample_voice_index(sample_idx), .o_pipeline_state(pstate),
    .o_voice_index(vidx), .o_sample_l(out_l), .o_sample_r(out_r),
    .o_sample_valid(valid), .o_clip(clip));

  always #5 clk = ~clk;

  // Upstream model: sample for the voice one slot behind the head
  always @(negedge clk) begin
    up_idx = (vidx == '0) ? IW'(NV - 1) : vidx - 1'b1;
    sample_idx = up_idx;
    sample = samples[up_idx[1:0]];
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic spi_write(input logic [IW-1:0] idx, input logic [7:0] val);
    @(negedge clk); spi_flag = 1'b1; spi_idx = idx; spi_pan = val;
    @(negedge clk); spi_flag = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NV; i++) samples[i] = SW'(v);
  endtask

  task automatic wait_pulse(input int maxc, output int n, output bit got);
    n = 0; got = 1'b0;
    while (n < maxc && !got) begin
      @(negedge clk); n++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic wait_v2_capture(output bit ok);
    int cnt = 0;
    while (!(pstate == 2'd2 && vidx == IW'(3)) && cnt < 20) begin
      @(negedge clk); cnt++;
    end
    ok = (pstate == 2'd2 && vidx == IW'(3));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pstate !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", pstate); end
    checks++; if (vidx !== '0) begin errors++; $display("FAIL reset_voice got %0d exp 0", vidx); end
    checks++; if (out_l !== '0 || out_r !== '0) begin errors++; $display("FAIL reset_out got %0d/%0d exp 0/0", out_l, out_r); end
    checks++; if (valid !== 1'b0 || clip !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", valid, clip); end
  endtask

  task automatic test_sequencer();
    int exp_s [10] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
    int exp_v [10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (pstate !== 2'(exp_s[k])) begin errors++; $display("FAIL seq_state[%0d] got %0d exp %0d", k, pstate, exp_s[k]); end
      checks++; if (vidx !== IW'(exp_v[k])) begin errors++; $display("FAIL seq_voice[%0d] got %0d exp %0d", k, vidx, exp_v[k]); end
    end
  endtask

  task automatic test_centre_pan();
    int n; bit got;
    set_all(1000);
    do_reset();
    wait_pulse(40, n, got);
    checks++; if (!got || n != 14) begin errors++; $display("FAIL centre_latency got %0d (seen %0d) exp 14", n, got); end
    wait_pulse(40, n, got);
    checks++; if (!got || n != 12) begin errors++; $display("FAIL centre_period got %0d (seen %0d) exp 12", n, got); end
    checks++; if (out_l !== 16'sd2000 || out_r !== 16'sd2000) begin errors++; $display("FAIL centre_out got %0d/%0d exp 2000/2000", out_l, out_r); end
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL centre_clip got %b exp 0", clip); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL centre_pulse_width got %b exp 0", valid); end
    checks++; if (out_l !== 16'sd2000 || out_r !== 16'sd2000) begin errors++; $display("FAIL centre_hold got %0d/%0d exp 2000/2000", out_l, out_r); end
  endtask

  task automatic test_hard_pan();
    int n; bit got;
    samples[0] = -16'sd1000; samples[1] = 16'sd512; samples[2] = '0; samples[3] = '0;
    do_reset();
    spi_write(IW'(0), 8'd0);
    spi_write(IW'(1), 8'd255);
    wait_pulse(40, n, got);
    wait_pulse(40, n, got);
    checks++; if (!got || out_l !== -16'sd998 || out_r !== 16'sd510) begin errors++; $display("FAIL hard_pan got %0d/%0d exp -998/510", out_l, out_r); end
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL hard_pan_clip got %b exp 0", clip); end
  endtask

  task automatic test_saturation();
    int n; bit got;
    int vals  [5] = '{32767, -32768, 8191, 8192, -8192};
    int exp_l [5] = '{32767, -32768, 32764, 32767, -32768};
    bit exp_c [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    set_all(0);
    do_reset();
    for (int v = 0; v < NV; v++) spi_write(IW'(v), 8'd0);
    wait_pulse(40, n, got);
    for (int t = 0; t < 5; t++) begin
      set_all(vals[t]);
      wait_pulse(40, n, got);
      checks++; if (!got || out_l !== OW'(exp_l[t]) || out_r !== '0) begin errors++; $display("FAIL sat_out[%0d] got %0d/%0d exp %0d/0", t, out_l, out_r, exp_l[t]); end
      checks++; if (clip !== exp_c[t]) begin errors++; $display("FAIL sat_clip[%0d] got %b exp %b", t, clip, exp_c[t]); end
    end
  endtask

  task automatic test_pan_race();
    int n; bit got, ok;
    set_all(1000);
    do_reset();
    wait_pulse(40, n, got);
    wait_v2_capture(ok);
    checks++; if (!ok) begin errors++; $display("FAIL race_sync got %0d/%0d exp 2/3", pstate, vidx); end
    spi_flag = 1'b1; spi_idx = IW'(2); spi_pan = 8'd0;
    @(negedge clk); spi_flag = 1'b0;
    wait_pulse(40, n, got);
    checks++; if (!got || out_l !== 16'sd2000 || out_r !== 16'sd2000) begin errors++; $display("FAIL race_old_pan got %0d/%0d exp 2000/2000", out_l, out_r); end
    wait_pulse(40, n, got);
    checks++; if (!got || out_l !== 16'sd2500 || out_r !== 16'sd1500) begin errors++; $display("FAIL race_new_pan got %0d/%0d exp 2500/1500", out_l, out_r); end
    spi_write(IW'(200), 8'd0);
    wait_pulse(40, n, got);
    wait_pulse(40, n, got);
    checks++; if (!got || out_l !== 16'sd2500 || out_r !== 16'sd1500) begin errors++; $display("FAIL oob_write got %0d/%0d exp 2500/1500", out_l, out_r); end
  endtask

  task automatic test_reset_mid_frame();
    int n; bit got, ok;
    set_all(1000);
    do_reset();
    spi_write(IW'(1), 8'd0);
    wait_pulse(40, n, got);
    checks++; if (!got || out_l !== 16'sd2500) begin errors++; $display("FAIL mid_pre got %0d exp 2500", out_l); end
    wait_v2_capture(ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (!ok || out_l !== '0 || out_r !== '0 || valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out got %0d/%0d v%b exp 0/0 v0", out_l, out_r, valid); end
    checks++; if (pstate !== 2'd0 || vidx !== '0) begin errors++; $display("FAIL mid_reset_seq got %0d/%0d exp 0/0", pstate, vidx); end
    wait_pulse(40, n, got);
    checks++; if (!got || n != 14) begin errors++; $display("FAIL mid_latency got %0d (seen %0d) exp 14", n, got); end
    checks++; if (out_l !== 16'sd2000 || out_r !== 16'sd2000) begin errors++; $display("FAIL mid_fresh got %0d/%0d exp 2000/2000", out_l, out_r); end
  endtask

  initial begin
    rst_n = 1'b0; spi_flag = 1'b0; spi_idx = '0; spi_pan = '0;
    set_all(0);
    test_reset();
    test_sequencer();
    test_centre_pan();
    test_hard_pan();
    test_saturation();
    test_pan_race();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
